// File: rtl/uart_receiver.sv
// uart_receiver: oversampling 8N1 serial receiver.
// The asynchronous line is brought into the clk domain with a two-flop
// synchronizer. A START/DATA/STOP state machine samples each bit at its centre
// and advances only on sample_tick. Completed frames are reported with one-cycle
// rx_valid or frame_error pulses.
module uart_receiver #(
  parameter int DATA_SIZE = 8,
  parameter int SAMPLE    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 serial_data_in,
  output logic [DATA_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(SAMPLE);
  localparam int IDX_W = $clog2(DATA_SIZE + 1);

  // Tick count at the centre of the start bit, measured from the falling edge.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SAMPLE / 2 - 1);
  // Tick count one full bit period after the previous sampling point.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic                 sync1_r;
  logic                 sync2_r;
  logic                 line_s;
  state_t               state_r;
  state_t               state_nxt_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_nxt_s;
  logic [IDX_W-1:0]     idx_r;
  logic [IDX_W-1:0]     idx_nxt_s;
  logic [DATA_SIZE-1:0] shift_r;
  logic [DATA_SIZE-1:0] shift_nxt_s;
  logic                 stop_sample_s;
  logic                 valid_set_s;
  logic                 err_set_s;
  logic [DATA_SIZE-1:0] rx_data_r;
  logic                 rx_valid_r;
  logic                 frame_error_r;
  logic                 rx_busy_r;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= serial_data_in;
      sync2_r <= sync1_r;
    end
  end

  assign line_s = sync2_r;

  // State register together with the tick counter, bit index and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      shift_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      shift_r <= shift_nxt_s;
    end
  end

  // Next-state logic; everything holds unless sample_tick is high.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    shift_nxt_s = shift_r;
    if (sample_tick) begin
      case (state_r)
        ST_IDLE: begin
          cnt_nxt_s = '0;
          if (!line_s) begin
            state_nxt_s = ST_START;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_START: begin
          if (cnt_r == CNT_HALF) begin
            cnt_nxt_s = '0;
            if (!line_s) begin
              state_nxt_s = ST_DATA;
              idx_nxt_s   = '0;
            end else begin
              // Start bit did not survive to its centre: treat as a glitch.
              state_nxt_s = ST_IDLE;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_nxt_s   = '0;
            shift_nxt_s = {line_s, shift_r[DATA_SIZE-1:1]};
            idx_nxt_s   = idx_r + IDX_W'(1);
            if (idx_r == IDX_LAST) begin
              state_nxt_s = ST_STOP;
            end else begin
              state_nxt_s = ST_DATA;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_nxt_s   = '0;
            state_nxt_s = ST_IDLE;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
          idx_nxt_s   = '0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output decode: the stop bit is judged on the tick that samples its centre.
  always_comb begin
    stop_sample_s = 1'b0;
    if (sample_tick && (state_r == ST_STOP) && (cnt_r == CNT_LAST)) begin
      stop_sample_s = 1'b1;
    end else begin
      stop_sample_s = 1'b0;
    end
    valid_set_s = stop_sample_s & line_s;
    err_set_s   = stop_sample_s & ~line_s;
  end

  // Output registers: pulses land the cycle after the stop-bit tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_r     <= '0;
      rx_valid_r    <= 1'b0;
      frame_error_r <= 1'b0;
      rx_busy_r     <= 1'b0;
    end else begin
      rx_valid_r    <= valid_set_s;
      frame_error_r <= err_set_s;
      rx_busy_r     <= (state_nxt_s != ST_IDLE);
      if (valid_set_s) begin
        rx_data_r <= shift_r;
      end else begin
        rx_data_r <= rx_data_r;
      end
    end
  end

  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign frame_error = frame_error_r;
  assign rx_busy     = rx_busy_r;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames with a scoreboard. Stimulus pushes the
// expected outcome of each frame; a monitor pops and compares on every
// rx_valid / frame_error pulse.
module tb_uart_receiver;

  logic       clk;
  logic       reset;
  logic       sample_tick;
  logic       serial_data_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       rx_busy;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] last_good = 8'h00;
  logic       tick_en = 1'b1;
  int         div = 0;

  uart_receiver #(.DATA_SIZE(8), .SAMPLE(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_tick    (sample_tick),
    .serial_data_in (serial_data_in),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .frame_error    (frame_error),
    .rx_busy        (rx_busy)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One sample_tick every 4 clk, gated by tick_en; changes on the falling edge.
  initial begin
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      sample_tick = tick_en && (div == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Wait for n ticks seen by the DUT; returns just after the last tick's edge.
  task automatic wait_ticks(input int n);
    int c = 0;
    int guard = 0;
    while (c < n && guard < n * 4 + 400) begin
      @(posedge clk);
      guard++;
      if (sample_tick) c++;
    end
    if (c < n) check("tick_timeout", 32'(c), 32'(n));
    #1;
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    serial_data_in = b;
    wait_ticks(16);
  endtask

  task automatic idle(input int nbits);
    @(negedge clk);
    serial_data_in = 1'b1;
    wait_ticks(16 * nbits);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    if (stop) begin
      exp_q.push_back({1'b0, d});
      last_good = d;
    end else begin
      exp_q.push_back({1'b1, last_good});
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("queue_drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every output pulse must match the oldest expected outcome.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rx_valid || frame_error) begin
        check("pulse_exclusive", 32'(rx_valid & frame_error), 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: got valid=%0b err=%0b data=0x%0h, required no pulse",
                   rx_valid, frame_error, rx_data);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind_err", 32'(frame_error), 32'(e.err));
          check("rx_data", 32'(rx_data), 32'(e.data));
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bc;
    int stall_bad;
    logic [7:0] held;
    reset = 1'b1;
    serial_data_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_frame_error", 32'(frame_error), 32'd0);
    check("reset_rx_busy", 32'(rx_busy), 32'd0);
    reset = 1'b0;
    idle(2);

    // Single good frame 0xA5 with busy-length measurement (152 ticks = 608 clk).
    bc = 0;
    fork
      begin
        send_frame(8'hA5, 1'b1);
        idle(1);
      end
      begin
        repeat (700) begin
          @(negedge clk);
          if (rx_busy) bc++;
        end
      end
    join
    wait_drain();
    check("busy_cycles_a5", 32'(bc), 32'd608);
    check("rx_data_after_a5", 32'(rx_data), 32'hA5);

    // Start-bit glitch: low for 4 ticks, back high before the centre sample.
    held = rx_data;
    @(negedge clk);
    serial_data_in = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    serial_data_in = 1'b1;
    wait_ticks(2);
    check("glitch_busy_mid", 32'(rx_busy), 32'd1);
    wait_ticks(6);
    check("glitch_busy_end", 32'(rx_busy), 32'd0);
    check("glitch_rx_data", 32'(rx_data), 32'(held));
    idle(1);

    // Framing error on 0x3C: rx_data must keep 0xA5.
    send_frame(8'h3C, 1'b0);
    idle(2);
    wait_drain();
    check("ferr_rx_data_kept", 32'(rx_data), 32'hA5);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    idle(1);
    wait_drain();

    // Reset during bit 3 of an aborted 0xC3 frame, then 0x5A.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    @(negedge clk);
    serial_data_in = 1'b0;
    wait_ticks(8);
    check("busy_before_reset", 32'(rx_busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    serial_data_in = 1'b1;
    #1;
    check("midreset_busy_async", 32'(rx_busy), 32'd0);
    repeat (10) @(negedge clk);
    check("midreset_rx_data", 32'(rx_data), 32'h00);
    check("midreset_rx_valid", 32'(rx_valid), 32'd0);
    check("midreset_frame_error", 32'(frame_error), 32'd0);
    check("midreset_rx_busy", 32'(rx_busy), 32'd0);
    reset = 1'b0;
    last_good = 8'h00;
    idle(3);
    send_frame(8'h5A, 1'b1);
    idle(1);
    wait_drain();
    check("rx_data_after_5a", 32'(rx_data), 32'h5A);

    // Tick stall of 100 clk in the middle of a 0x96 frame.
    stall_bad = 0;
    fork
      begin
        send_frame(8'h96, 1'b1);
        idle(1);
      end
      begin
        wait_ticks(80);
        tick_en = 1'b0;
        repeat (100) begin
          @(negedge clk);
          if (!rx_busy || rx_valid || frame_error) stall_bad++;
        end
        tick_en = 1'b1;
      end
    join
    check("stall_frozen", 32'(stall_bad), 32'd0);
    wait_drain();
    check("rx_data_after_96", 32'(rx_data), 32'h96);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
